// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and defaults for the bit-serial adder
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/ready request and result bundle of the serial adder
interface serial_adder_if #(
  parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit combinational full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder around a single full-adder cell
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last;

  assign accept = (state != BUSY) && bus.start;
  assign last   = (state == BUSY) && (cnt == LAST_CNT);

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // Result bits arrive LSB first, so each new bit enters at the MSB end.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_nxt = fa_s;
    end else begin : g_res_wn
      assign res_nxt = {fa_s, res_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      carry  <= bus.cin;
      cnt    <= '0;
    end else if (state == BUSY) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      carry  <= fa_c;
      cnt    <= cnt + CNT_W'(1);
      // Published results stay frozen until the final bit is produced.
      if (last) begin
        sum_q  <= res_nxt;
        cout_q <= fa_c;
      end
    end
  end

  assign bus.ready = (state != BUSY);
  assign bus.busy  = (state == BUSY);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder and its full_adder cell
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   done_pulses = 0;
  logic [W:0] exp_q[$];

  logic fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic [1:0] fa_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  serial_adder_if #(.WIDTH(W)) bus();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  full_adder u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (fa_cin),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      done_pulses++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 sum=%0h expected no pending result", bus.sum);
      end else begin
        chk("result", {23'b0, bus.cout, bus.sum}, {23'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [W:0] exp);
    int t = 0;
    while (bus.ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 0, 1);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int nbusy);
    int t = 0;
    nbusy = 0;
    while (bus.done !== 1'b1 && t < 50) begin
      if (bus.busy === 1'b1) nbusy++;
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int nb;
    int p0;
    int t;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    fa_a = 0; fa_b = 0; fa_cin = 0;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      {fa_a, fa_b, fa_cin} = v;
      #1;
      chk($sformatf("fa_vec%0d", i), {30'b0, fa_cout, fa_sum}, {30'b0, fa_exp[i]});
    end

    @(negedge clk);
    chk("rst_busy",  bus.busy,  0);
    chk("rst_done",  bus.done,  0);
    chk("rst_ready", bus.ready, 1);
    chk("rst_sum",   bus.sum,   0);
    chk("rst_cout",  bus.cout,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'h5A, 8'h3C, 1'b0, 9'h096);
    wait_done(nb);
    chk("busy_cycles_5a3c", nb, 8);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);

    issue(8'hFF, 8'h01, 1'b0, 9'h100);
    wait_done(nb);
    @(negedge clk);
    issue(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    wait_done(nb);
    @(negedge clk);
    issue(8'h7F, 8'h01, 1'b1, 9'h081);
    wait_done(nb);
    @(negedge clk);

    // start held high with changing operands while busy, then re-issued in DONE
    p0 = done_pulses;
    bus.start = 1'b1;
    bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    exp_q.push_back(9'h030);
    @(negedge clk);
    nb = 0;
    t = 0;
    while (bus.done !== 1'b1 && t < 50) begin
      if (bus.busy === 1'b1) nb++;
      bus.a = 8'hC3 ^ 8'(t);
      bus.b = 8'h77;
      bus.cin = 1'b1;
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("hold_done_timeout", 0, 1);
    chk("hold_busy_cycles", nb, 8);
    bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
    exp_q.push_back(9'h002);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_done_low", bus.done, 0);
    chk("b2b_sum_held", bus.sum, 8'h30);
    chk("hold_single_pulse", done_pulses - p0, 1);
    repeat (4) @(negedge clk);
    chk("b2b_sum_held_mid", bus.sum, 8'h30);
    wait_done(nb);
    @(negedge clk);
    chk("b2b_total_pulses", done_pulses - p0, 2);

    issue(8'hAA, 8'h55, 1'b0, 9'h0FF);
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", bus.busy, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_busy",  bus.busy,  0);
    chk("abort_done",  bus.done,  0);
    chk("abort_ready", bus.ready, 1);
    chk("abort_sum",   bus.sum,   0);
    chk("abort_cout",  bus.cout,  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = done_pulses;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_pulses - p0, 0);

    issue(8'h80, 8'h80, 1'b1, 9'h101);
    wait_done(nb);
    chk("busy_cycles_after_abort", nb, 8);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
